// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator: 100 MHz half-period table,
// FSM state encoding, note indices and the divisor helper.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } tone_state_t;

    localparam int unsigned NOTE_C4 = 0;
    localparam int unsigned NOTE_D4 = 1;
    localparam int unsigned NOTE_E4 = 2;
    localparam int unsigned NOTE_F4 = 3;
    localparam int unsigned NOTE_G4 = 4;
    localparam int unsigned NOTE_A4 = 5;
    localparam int unsigned NOTE_B4 = 6;
    localparam int unsigned NOTE_C5 = 7;

    localparam int unsigned TABLE_SIZE = 8;

    localparam logic [31:0] HALF_PERIOD [0:7] = '{
        32'd191110, 32'd170265, 32'd151685, 32'd143172,
        32'd127551, 32'd113636, 32'd101215, 32'd95602
    };

    // Half-period in clocks after scaling and octave shift; never returns 0.
    function automatic logic [31:0] note_divisor(input logic [31:0] idx,
                                                 input logic octave_up,
                                                 input int unsigned shift);
        logic [31:0] w_d;
        if (idx < 32'(TABLE_SIZE))
            w_d = HALF_PERIOD[idx[2:0]] >> (shift + 32'(octave_up));
        else
            w_d = 32'd0;
        return (w_d == 32'd0) ? 32'd1 : w_d;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running tempo counter: one-cycle tick and a toggling level every
// BEAT_CYCLES clocks; a sync pulse restarts the count silently.
module beat_timer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int BEAT_W      = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sync,
    output logic o_tick,
    output logic o_beat
);

    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEAT_CYCLES - 1);

    logic [BEAT_W-1:0] r_bcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bcnt <= '0;
            o_tick <= 1'b0;
            o_beat <= 1'b0;
        end else begin
            o_tick <= 1'b0;
            // Sync beats a coincident wrap: no tick, no toggle.
            if (i_sync) begin
                r_bcnt <= '0;
            end else if (r_bcnt == LAST) begin
                r_bcnt <= '0;
                o_tick <= 1'b1;
                o_beat <= ~o_beat;
            end else begin
                r_bcnt <= r_bcnt + BEAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_clock_gen.sv
// Selectable square-wave tone with glitch-free note changes and clean mute,
// plus the tempo beat generator.
module tone_clock_gen
    import tone_pkg::*;
#(
    parameter int          NUM_NOTES   = 8,
    parameter int          SEL_W       = 3,
    parameter int          CNT_W       = 18,
    parameter int unsigned DIV_SHIFT   = 0,
    parameter int          BEAT_CYCLES = 25_000_000,
    parameter int          BEAT_W      = 25
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [SEL_W-1:0] NOTE_SEL,
    input  logic             OCTAVE_UP,
    input  logic             NOTE_VALID,
    input  logic             ENABLE,
    input  logic             BEAT_SYNC,
    output logic             TONE,
    output logic             BUSY,
    output logic [SEL_W-1:0] CUR_NOTE,
    output logic             BEAT,
    output logic             BEAT_TICK
);

    tone_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dcur;
    logic [CNT_W-1:0] r_pend_d;
    logic [SEL_W-1:0] r_pend_sel;
    logic             r_pend_vld;

    logic             w_req_ok;
    logic             w_term;
    logic [CNT_W-1:0] w_div;

    assign w_req_ok = NOTE_VALID && (32'(NOTE_SEL) < 32'(NUM_NOTES));
    assign w_div    = CNT_W'(note_divisor(32'(NOTE_SEL), OCTAVE_UP, DIV_SHIFT));
    assign w_term   = (r_cnt == r_dcur - CNT_W'(1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dcur     <= '0;
            r_pend_d   <= '0;
            r_pend_sel <= '0;
            r_pend_vld <= 1'b0;
            TONE       <= 1'b0;
            BUSY       <= 1'b0;
            CUR_NOTE   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    TONE  <= 1'b0;
                    if (w_req_ok && ENABLE) begin
                        r_dcur   <= w_div;
                        CUR_NOTE <= NOTE_SEL;
                        r_state  <= ST_PLAY;
                        BUSY     <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
                    if (!ENABLE) begin
                        r_pend_vld <= 1'b0;
                        // Low half already, or falling this cycle: stop now.
                        if (!TONE || w_term) begin
                            TONE    <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                            BUSY    <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        if (w_term) begin
                            TONE <= ~TONE;
                            if (r_pend_vld) begin
                                r_dcur     <= r_pend_d;
                                CUR_NOTE   <= r_pend_sel;
                                r_pend_vld <= 1'b0;
                            end
                        end
                        // Placed after the apply so a request on the terminal
                        // cycle survives as the next pending value.
                        if (w_req_ok) begin
                            r_pend_d   <= w_div;
                            r_pend_sel <= NOTE_SEL;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_term) begin
                        r_cnt      <= '0;
                        TONE       <= 1'b0;
                        r_pend_vld <= 1'b0;
                        r_state    <= ST_IDLE;
                        BUSY       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    beat_timer #(
        .BEAT_CYCLES(BEAT_CYCLES),
        .BEAT_W     (BEAT_W)
    ) u_beat (
        .i_clk (CLK),
        .i_rst (RESET),
        .i_sync(BEAT_SYNC),
        .o_tick(BEAT_TICK),
        .o_beat(BEAT)
    );

endmodule

// File: tb/tb_tone_clock_gen.sv
// Directed bench for tone_clock_gen: tone toggle intervals and note indices
// are scoreboarded; beat, mute and reset behaviour checked at fixed edges.
module tb_tone_clock_gen;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] NOTE_SEL = '0;
    logic       OCTAVE_UP = 1'b0;
    logic       NOTE_VALID = 1'b0;
    logic       ENABLE = 1'b0;
    logic       BEAT_SYNC = 1'b0;
    logic       TONE, BUSY, BEAT, BEAT_TICK;
    logic [3:0] CUR_NOTE;

    tone_clock_gen #(
        .NUM_NOTES(8), .SEL_W(4), .CNT_W(18), .DIV_SHIFT(14),
        .BEAT_CYCLES(20), .BEAT_W(5)
    ) dut (
        .CLK(CLK), .RESET(RESET), .NOTE_SEL(NOTE_SEL), .OCTAVE_UP(OCTAVE_UP),
        .NOTE_VALID(NOTE_VALID), .ENABLE(ENABLE), .BEAT_SYNC(BEAT_SYNC),
        .TONE(TONE), .BUSY(BUSY), .CUR_NOTE(CUR_NOTE), .BEAT(BEAT),
        .BEAT_TICK(BEAT_TICK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ivl;
        int note;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_ev = 0;
    logic prev_tone = 1'b0;
    logic prev_busy = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Return just after edge k (inputs set now take effect at edge k+1).
    task automatic at_edge(input int k);
        while (cyc < k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input int ivl, input int note, input int n);
        exp_t e;
        e.ivl  = ivl;
        e.note = note;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic req(input int sel, input logic oct);
        NOTE_SEL   = 4'(sel);
        OCTAVE_UP  = oct;
        NOTE_VALID = 1'b1;
    endtask

    // Tone monitor: each toggle is matched against the next scoreboard entry.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            prev_tone = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (BUSY && !prev_busy) last_ev = cyc;
            if (TONE !== prev_tone) begin
                if (exp_q.size() == 0) begin
                    check("toggle_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("half_period", cyc - last_ev, e.ivl);
                    check("cur_note_at_toggle", int'(CUR_NOTE), e.note);
                end
                last_ev = cyc;
            end
            prev_tone = TONE;
            prev_busy = BUSY;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 10000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, a, e;
        // Reset state
        at_edge(2);
        check("rst_tone", int'(TONE), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_cur_note", int'(CUR_NOTE), 0);
        check("rst_beat", int'(BEAT), 0);
        check("rst_beat_tick", int'(BEAT_TICK), 0);
        at_edge(3);
        RESET = 1'b0;
        rel = 3;

        // Beat: ticks at rel+20k; sync on the third wrap cycle suppresses it
        at_edge(rel + 19);
        check("beat_pre_tick", int'(BEAT_TICK), 0);
        at_edge(rel + 20);
        check("beat_tick1", int'(BEAT_TICK), 1);
        check("beat_lvl1", int'(BEAT), 1);
        at_edge(rel + 21);
        check("beat_tick_1cyc", int'(BEAT_TICK), 0);
        at_edge(rel + 40);
        check("beat_tick2", int'(BEAT_TICK), 1);
        check("beat_lvl2", int'(BEAT), 0);
        at_edge(rel + 59);
        BEAT_SYNC = 1'b1;
        at_edge(rel + 60);
        BEAT_SYNC = 1'b0;
        check("sync_no_tick", int'(BEAT_TICK), 0);
        check("sync_no_toggle", int'(BEAT), 0);
        at_edge(rel + 79);
        check("sync_pre_tick", int'(BEAT_TICK), 0);
        at_edge(rel + 80);
        check("sync_tick", int'(BEAT_TICK), 1);
        check("sync_lvl", int'(BEAT), 1);

        // C4 start: accept edge a, toggles every 11 edges
        at_edge(90);
        ENABLE = 1'b1;
        req(0, 1'b0);
        a = 91;
        push(11, 0, 4);
        at_edge(a);
        NOTE_VALID = 1'b0;
        check("start_busy", int'(BUSY), 1);
        check("start_note", int'(CUR_NOTE), 0);
        check("start_tone", int'(TONE), 0);

        // A4 requested mid half-period, applied at the a+55 toggle
        at_edge(a + 49);
        req(5, 1'b0);
        push(11, 5, 1);
        push(6, 5, 3);
        at_edge(a + 50);
        NOTE_VALID = 1'b0;
        check("pending_no_early_switch", int'(CUR_NOTE), 0);

        // C5 octave up (D=2), then C5 (D=5), then out-of-range sel=8
        at_edge(a + 74);
        req(7, 1'b1);
        push(6, 7, 1);
        push(2, 7, 4);
        at_edge(a + 75);
        NOTE_VALID = 1'b0;
        at_edge(a + 85);
        req(7, 1'b0);
        push(5, 7, 2);
        at_edge(a + 86);
        NOTE_VALID = 1'b0;
        at_edge(a + 94);
        req(8, 1'b0);
        at_edge(a + 95);
        NOTE_VALID = 1'b0;

        // Request on the a+97 terminal edge becomes pending for a+102
        at_edge(a + 96);
        req(0, 1'b0);
        push(5, 0, 1);
        push(11, 0, 1);
        at_edge(a + 97);
        NOTE_VALID = 1'b0;

        // Mute while high: drain to the a+124 fall; requests during drain ignored
        at_edge(a + 117);
        ENABLE = 1'b0;
        push(11, 0, 1);
        at_edge(a + 119);
        check("drain_busy", int'(BUSY), 1);
        check("drain_tone", int'(TONE), 1);
        ENABLE = 1'b1;
        req(5, 1'b0);
        at_edge(a + 120);
        NOTE_VALID = 1'b0;
        at_edge(a + 124);
        check("mute_busy", int'(BUSY), 0);
        check("mute_tone", int'(TONE), 0);
        at_edge(a + 150);
        check("idle_busy", int'(BUSY), 0);
        check("idle_tone", int'(TONE), 0);
        check("idle_note", int'(CUR_NOTE), 0);
        check("sb_empty_idle", exp_q.size(), 0);

        // Asynchronous reset mid-note, on a tick edge with BEAT high
        e = rel + 80 + 40 * 5;
        at_edge(e - 3);
        req(7, 1'b1);
        push(2, 7, 1);
        at_edge(e - 2);
        NOTE_VALID = 1'b0;
        at_edge(e);
        check("pre_rst_tone", int'(TONE), 1);
        check("pre_rst_tick", int'(BEAT_TICK), 1);
        check("pre_rst_beat", int'(BEAT), 1);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_tone", int'(TONE), 0);
        check("arst_busy", int'(BUSY), 0);
        check("arst_beat", int'(BEAT), 0);
        check("arst_beat_tick", int'(BEAT_TICK), 0);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
